// File: rtl/alpaca_fft_pkg.sv
// Shared types and sizing for the radix-2 FFT datapath.
package alpaca_fft_pkg;

    localparam int unsigned FFT_LEN = 16;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned TUSER_W = 8;
    localparam int unsigned HALF    = FFT_LEN / 2;

    // Complex sample, packed as {im, re}
    typedef struct packed {
        logic signed [WIDTH-1:0] im;
        logic signed [WIDTH-1:0] re;
    } cx_t;

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } sched_state_e;

endpackage

// File: rtl/alpaca_half_buf.sv
// Half-frame sample store: synchronous write, asynchronous read.
module alpaca_half_buf #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 40,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alpaca_bfly_sched.sv
// Radix-2 DIF butterfly sequencer: buffers the first half of a frame and
// pairs each second-half sample with its buffered partner.
// Optional feature macro: SCHED_ERR_CNT_EN adds a saturating err_cnt output.
module alpaca_bfly_sched #(
    parameter int unsigned FFT_LEN = alpaca_fft_pkg::FFT_LEN,
    parameter int unsigned WIDTH   = alpaca_fft_pkg::WIDTH,
    parameter int unsigned TUSER_W = alpaca_fft_pkg::TUSER_W,
    localparam int unsigned KW     = (FFT_LEN > 4) ? $clog2(FFT_LEN / 2) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*WIDTH-1:0]   s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tlast,
    input  logic [TUSER_W-1:0]   s_tuser,
    output logic [2*WIDTH-1:0]   x1_tdata,
    output logic                 x1_tvalid,
    input  logic                 x1_tready,
    output logic [TUSER_W-1:0]   x1_tuser,
    output logic                 x1_tlast,
    output logic [2*WIDTH-1:0]   x2_tdata,
    output logic                 x2_tvalid,
    input  logic                 x2_tready,
    output logic [TUSER_W-1:0]   x2_tuser,
    output logic                 x2_tlast,
    output logic [KW-1:0]        wk_idx,
`ifdef SCHED_ERR_CNT_EN
    output logic [15:0]          err_cnt,
`endif
    output logic                 frame_err
);

    import alpaca_fft_pkg::*;

    localparam int unsigned PAIRS = FFT_LEN / 2;
    localparam int unsigned DW    = 2 * WIDTH;
    localparam int unsigned BW    = TUSER_W + DW;
    localparam logic [KW-1:0] K_LAST = KW'(PAIRS - 1);

    sched_state_e state, state_next;
    logic [KW-1:0] cnt, cnt_next;
    logic          buf_we;
    logic          pair_load;
    logic          err_c;
    logic          out_valid;
    logic          both_ready;
    logic          accept;
    logic [BW-1:0] rd_entry;

    assign both_ready = x1_tready & x2_tready;
    assign s_tready   = ~rst & ((state == FILL) | ~out_valid | both_ready);
    assign accept     = s_tvalid & s_tready;

    alpaca_half_buf #(
        .DEPTH (PAIRS),
        .DW    (BW),
        .AW    (KW)
    ) u_half_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (cnt),
        .wdata ({s_tuser, s_tdata}),
        .raddr (cnt),
        .rdata (rd_entry)
    );

    // State and half-frame index register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state, buffer write, pair load and framing-error detection
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        buf_we     = 1'b0;
        pair_load  = 1'b0;
        err_c      = 1'b0;
        if (accept) begin
            case (state)
                FILL: begin
                    if (s_tlast) begin
                        // Any tlast in the first half is early: drop and resync
                        err_c    = 1'b1;
                        cnt_next = '0;
                    end else begin
                        buf_we = 1'b1;
                        if (cnt == K_LAST) begin
                            cnt_next   = '0;
                            state_next = PAIR;
                        end else begin
                            cnt_next = cnt + KW'(1);
                        end
                    end
                end
                PAIR: begin
                    if (s_tlast && (cnt != K_LAST)) begin
                        err_c      = 1'b1;
                        cnt_next   = '0;
                        state_next = FILL;
                    end else begin
                        pair_load = 1'b1;
                        if (cnt == K_LAST) begin
                            // Missing tlast still completes the pair
                            err_c      = ~s_tlast;
                            cnt_next   = '0;
                            state_next = FILL;
                        end else begin
                            cnt_next = cnt + KW'(1);
                        end
                    end
                end
                default: begin
                    state_next = FILL;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // One-entry output stage shared by both butterfly ports
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            x1_tdata  <= '0;
            x1_tuser  <= '0;
            x2_tdata  <= '0;
            x2_tuser  <= '0;
            x2_tlast  <= 1'b0;
            wk_idx    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_c;
            if (pair_load) begin
                out_valid <= 1'b1;
                x1_tdata  <= rd_entry[DW-1:0];
                x1_tuser  <= rd_entry[BW-1:DW];
                x2_tdata  <= s_tdata;
                x2_tuser  <= s_tuser;
                x2_tlast  <= (cnt == K_LAST);
                wk_idx    <= cnt;
            end else if (both_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign x1_tvalid = out_valid;
    assign x2_tvalid = out_valid;
    assign x1_tlast  = 1'b0;

`ifdef SCHED_ERR_CNT_EN
    // Saturating count of framing errors
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (frame_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule
